// File: rtl/ip_psram_arbiter_pkg.sv
// ip_psram_arbiter_pkg
//  Shared types and helpers for the PSRAM arbiter. It holds the FSM state codes, the
//  requester port IDs, the operation encoding and the grant selection function.
//  Ports: none (package).
package ip_psram_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2
   } state_e;

   typedef enum logic {
      Port0 = 1'b0,  // MSX cartridge bus
      Port1 = 1'b1   // loader / DMA
   } port_e;

   typedef enum logic {
      OpRd = 1'b0,
      OpWr = 1'b1
   } op_e;

   localparam int unsigned TimerW = 8;

   // Grant choice among occupied slots. Only called when at least one slot is pending.
   function automatic port_e pick_port(input logic  pend0,
                                       input logic  pend1,
                                       input port_e rr_next,
                                       input logic  fixed_prio);
      if (pend0 && pend1) begin
         return fixed_prio ? Port0 : rr_next;
      end else if (pend1) begin
         return Port1;
      end
      return Port0;
   endfunction

   function automatic port_e other_port(input port_e p);
      return (p == Port0) ? Port1 : Port0;
   endfunction

endpackage

// File: rtl/ip_psram_arb_slot.sv
// ip_psram_arb_slot
//  One-entry request slot for one requester. It latches a 1-cycle rd/wr pulse with its
//  address and write data, and holds them until the arbiter completes the access.
//  Ports:
//   clk, n_reset         clock, synchronous active-low reset
//   rd, wr               request pulses from the requester
//   address, wdata       sampled together with the pulse
//   clear                completion of this slot's access (from the arbiter)
//   err_clear            clears the sticky overrun flag
//   pending              slot occupied
//   op, slot_address,    captured request
//   slot_wdata
//   overrun              sticky: a pulse was dropped
module ip_psram_arb_slot
   import ip_psram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 22,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] wdata,
   input  logic              clear,
   input  logic              err_clear,
   output logic              pending,
   output op_e               op,
   output logic [ADDR_W-1:0] slot_address,
   output logic [DATA_W-1:0] slot_wdata,
   output logic              overrun
);

   logic pulse;
   logic accept;
   logic drop;

   assign pulse  = rd | wr;
   // A pulse landing in the completion cycle reloads the slot instead of overrunning it.
   assign accept = pulse & (~pending | clear);
   // rd+wr together: the write is kept, the read counts as dropped.
   assign drop   = (pulse & pending & ~clear) | (rd & wr);

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         pending      <= 1'b0;
         op           <= OpRd;
         slot_address <= '0;
         slot_wdata   <= '0;
         overrun      <= 1'b0;
      end else begin
         if (accept) begin
            pending      <= 1'b1;
            op           <= wr ? OpWr : OpRd;
            slot_address <= address;
            slot_wdata   <= wdata;
         end else if (clear) begin
            pending <= 1'b0;
         end

         // Setting wins over a same-cycle clear.
         if (drop) begin
            overrun <= 1'b1;
         end else if (err_clear) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ip_psram_arbiter.sv
// ip_psram_arbiter
//  Shares the psram0 channel between the MSX cartridge bus (port0) and the loader/DMA
//  (port1). Each port has a one-entry slot; the FSM grants one slot at a time, issues a
//  single rd/wr pulse to the controller, waits for completion or timeout, and routes read
//  data back to the owning port only.
//  Ports:
//   clk, n_reset                 clock, synchronous active-low reset
//   reqN_rd/wr/address/wdata     request pulse and payload (N = 0, 1)
//   reqN_pending                 slot occupied (busy)
//   reqN_rdata, reqN_rdata_en    read return, valid with the pulse
//   reqN_overrun                 sticky: request pulse dropped
//   psram0_rd/wr                 1-cycle command pulses to the controller
//   psram0_address/wdata         held from issue until the next grant
//   psram0_busy                  controller busy
//   psram0_rdata, rdata_en       controller read return
//   timeout_err                  sticky: an access timed out
//   err_clear                    clears all sticky flags
module ip_psram_arbiter
   import ip_psram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W     = 22,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              req0_rd,
   input  logic              req0_wr,
   input  logic [ADDR_W-1:0] req0_address,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_pending,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_rdata_en,
   output logic              req0_overrun,
   input  logic              req1_rd,
   input  logic              req1_wr,
   input  logic [ADDR_W-1:0] req1_address,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_pending,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_rdata_en,
   output logic              req1_overrun,
   output logic              psram0_rd,
   output logic              psram0_wr,
   output logic [ADDR_W-1:0] psram0_address,
   output logic [DATA_W-1:0] psram0_wdata,
   input  logic              psram0_busy,
   input  logic [DATA_W-1:0] psram0_rdata,
   input  logic              psram0_rdata_en,
   output logic              timeout_err,
   input  logic              err_clear
);

   localparam logic [TimerW-1:0] TimeoutInit = TimerW'(TIMEOUT);

   op_e               slot0_op;
   op_e               slot1_op;
   logic [ADDR_W-1:0] slot0_address;
   logic [ADDR_W-1:0] slot1_address;
   logic [DATA_W-1:0] slot0_wdata;
   logic [DATA_W-1:0] slot1_wdata;

   state_e            state;
   port_e             owner;
   op_e               owner_op;
   port_e             rr_next;
   logic [TimerW-1:0] timer;

   port_e             grant;
   op_e               grant_op;
   logic [ADDR_W-1:0] grant_address;
   logic [DATA_W-1:0] grant_wdata;
   logic              complete;
   logic              timed_out;
   logic [DATA_W-1:0] ret_data;
   logic              clear0;
   logic              clear1;

   ip_psram_arb_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slot0 (
      .clk          (clk),
      .n_reset      (n_reset),
      .rd           (req0_rd),
      .wr           (req0_wr),
      .address      (req0_address),
      .wdata        (req0_wdata),
      .clear        (clear0),
      .err_clear    (err_clear),
      .pending      (req0_pending),
      .op           (slot0_op),
      .slot_address (slot0_address),
      .slot_wdata   (slot0_wdata),
      .overrun      (req0_overrun)
   );

   ip_psram_arb_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_slot1 (
      .clk          (clk),
      .n_reset      (n_reset),
      .rd           (req1_rd),
      .wr           (req1_wr),
      .address      (req1_address),
      .wdata        (req1_wdata),
      .clear        (clear1),
      .err_clear    (err_clear),
      .pending      (req1_pending),
      .op           (slot1_op),
      .slot_address (slot1_address),
      .slot_wdata   (slot1_wdata),
      .overrun      (req1_overrun)
   );

   // Grant selection and completion detection.
   always_comb begin
      grant = pick_port(req0_pending, req1_pending, rr_next, FIXED_PRIO != 0);
      if (grant == Port0) begin
         grant_op      = slot0_op;
         grant_address = slot0_address;
         grant_wdata   = slot0_wdata;
      end else begin
         grant_op      = slot1_op;
         grant_address = slot1_address;
         grant_wdata   = slot1_wdata;
      end

      complete  = 1'b0;
      timed_out = 1'b0;
      if (state == StWait) begin
         // rdata_en only matters while a read waits; writes finish on the first idle cycle.
         complete = (owner_op == OpWr) ? ~psram0_busy : psram0_rdata_en;
         // The counter would reach zero this cycle: abort.
         if (!complete && (timer == TimerW'(1))) begin
            complete  = 1'b1;
            timed_out = 1'b1;
         end
      end
      ret_data = timed_out ? '1 : psram0_rdata;
   end

   assign clear0 = complete & (owner == Port0);
   assign clear1 = complete & (owner == Port1);

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state          <= StIdle;
         owner          <= Port0;
         owner_op       <= OpRd;
         rr_next        <= Port0;
         timer          <= '0;
         psram0_rd      <= 1'b0;
         psram0_wr      <= 1'b0;
         psram0_address <= '0;
         psram0_wdata   <= '0;
         req0_rdata     <= '0;
         req0_rdata_en  <= 1'b0;
         req1_rdata     <= '0;
         req1_rdata_en  <= 1'b0;
         timeout_err    <= 1'b0;
      end else begin
         psram0_rd     <= 1'b0;
         psram0_wr     <= 1'b0;
         req0_rdata_en <= 1'b0;
         req1_rdata_en <= 1'b0;

         // A timeout in the same cycle overrides this below.
         if (err_clear) begin
            timeout_err <= 1'b0;
         end

         unique case (state)
            StIdle: begin
               if ((req0_pending || req1_pending) && !psram0_busy) begin
                  owner          <= grant;
                  owner_op       <= grant_op;
                  rr_next        <= other_port(grant);
                  psram0_rd      <= (grant_op == OpRd);
                  psram0_wr      <= (grant_op == OpWr);
                  psram0_address <= grant_address;
                  psram0_wdata   <= grant_wdata;
                  timer          <= TimeoutInit;
                  state          <= StIssue;
               end
            end
            StIssue: begin
               state <= StWait;
            end
            StWait: begin
               timer <= timer - TimerW'(1);
               if (complete) begin
                  state <= StIdle;
                  if (timed_out) begin
                     timeout_err <= 1'b1;
                  end
                  if (owner_op == OpRd) begin
                     if (owner == Port0) begin
                        req0_rdata    <= ret_data;
                        req0_rdata_en <= 1'b1;
                     end else begin
                        req1_rdata    <= ret_data;
                        req1_rdata_en <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule
